// File: rtl/tile_board_scanner.sv
// tile_board_scanner
//   Display-side reader of the 16-entry block-type table. Generates VGA raster
//   timing from a divided pixel tick and maps each active pixel onto a 4x4 board
//   of square tiles. It drives BlockID for the table lookup, samples the returned
//   BlockType one tick later and outputs the palette colour.
//   The raster-to-pins pipeline is two pixel ticks deep:
//     stage 0 : counters and combinational decode
//     stage 1 : BlockID / flags
//     stage 2 : colour and sync pins
//   Sync is delayed by the same two ticks so that it lines up with colour.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   BlockID      tile index {row[1:0], col[1:0]} for the block-table lookup
//   BlockType    tile content for BlockID, combinational from the table
//   vga_r/g/b    4-bit colour channels
//   vga_hs       horizontal sync, active low
//   vga_vs       vertical sync, active low
//   frame_start  one-clk pulse on the pixel tick at h_cnt=0, v_cnt=0
//
// Configuration macro
//   TILE_GRID_EN : when defined, board pixels with tx<2 or ty<2 show a grid colour.
module tile_board_scanner #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BOARD_X0 = 160,
    parameter int BOARD_Y0 = 80,
    parameter int TILE_PX  = 80
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] BlockID,
    input  logic [3:0] BlockType,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 32'sd1);
    localparam int VW      = $clog2(V_TOTAL + 32'sd1);
    localparam int TW      = $clog2(TILE_PX + 32'sd1);
    localparam int DW      = (PIX_DIV > 32'sd1) ? $clog2(PIX_DIV) : 32'sd1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 32'sd1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(32'sd1);
    localparam logic [HW-1:0] H_ONE    = HW'(32'sd1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 32'sd1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BX0      = HW'(BOARD_X0);
    localparam logic [HW-1:0] BX0_PRE  = HW'(BOARD_X0 - 32'sd1);
    localparam logic [HW-1:0] BX1      = HW'(BOARD_X0 + 32'sd4 * TILE_PX);
    localparam logic [VW-1:0] V_ONE    = VW'(32'sd1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 32'sd1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] BY0      = VW'(BOARD_Y0);
    localparam logic [VW-1:0] BY0_PRE  = VW'(BOARD_Y0 - 32'sd1);
    localparam logic [VW-1:0] BY1      = VW'(BOARD_Y0 + 32'sd4 * TILE_PX);
    localparam logic [TW-1:0] T_ONE    = TW'(32'sd1);
    localparam logic [TW-1:0] T_LAST   = TW'(TILE_PX - 32'sd1);
`ifdef TILE_GRID_EN
    localparam logic [TW-1:0] T_TWO    = TW'(32'sd2);
`endif

    // 12-bit RGB palette indexed by block type
    function automatic logic [11:0] palette_lookup(input logic [3:0] block_type);
        logic [11:0] rgb;
        case (block_type)
            4'h0:    rgb = 12'hCCB;
            4'h1:    rgb = 12'hEED;
            4'h2:    rgb = 12'hEEC;
            4'h3:    rgb = 12'hFB7;
            4'h4:    rgb = 12'hF96;
            4'h5:    rgb = 12'hF75;
            4'h6:    rgb = 12'hF53;
            4'h7:    rgb = 12'hEC7;
            4'h8:    rgb = 12'hEC6;
            4'h9:    rgb = 12'hEC5;
            4'hA:    rgb = 12'hEC3;
            4'hB:    rgb = 12'hEC2;
            default: rgb = 12'h333;
        endcase
        return rgb;
    endfunction

    logic [DW-1:0] div_r;
    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic [TW-1:0] tx_r, ty_r;
    logic [1:0]    col_r, row_r;
    logic          in_board_1_r, active_1_r, hs_1_r, vs_1_r;
`ifdef TILE_GRID_EN
    logic [TW-1:0] tx_1_r, ty_1_r;
`endif
    logic [3:0]    block_id_r;
    logic [11:0]   rgb_r;
    logic          hs_r, vs_r, frame_start_r;

    logic tick_s, h_last_s, v_last_s, hs_n_s, vs_n_s;
    logic h_in_s, v_in_s, in_board_s, active_s;
    logic [11:0] colour_s;

    // Stage 0: tick, wrap and region decode of the current raster position
    always_comb begin
        tick_s     = (div_r == DIV_LAST);
        h_last_s   = (h_cnt_r == H_LAST);
        v_last_s   = (v_cnt_r == V_LAST);
        hs_n_s     = !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
        vs_n_s     = !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
        h_in_s     = (h_cnt_r >= BX0) && (h_cnt_r < BX1);
        v_in_s     = (v_cnt_r >= BY0) && (v_cnt_r < BY1);
        in_board_s = h_in_s && v_in_s;
        active_s   = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    end

    // Stage 2 colour select; BlockType is consumed only at the tick edge
    always_comb begin
        colour_s = 12'h000;
        if (in_board_1_r) begin
`ifdef TILE_GRID_EN
            if ((tx_1_r < T_TWO) || (ty_1_r < T_TWO)) begin
                colour_s = 12'h776;
            end else begin
                colour_s = palette_lookup(BlockType);
            end
`else
            colour_s = palette_lookup(BlockType);
`endif
        end else if (active_1_r) begin
            colour_s = 12'h444;
        end else begin
            colour_s = 12'h000;
        end
    end

    // Pixel-tick divider and raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r   <= {DW{1'b0}};
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else begin
            if (tick_s) begin
                div_r <= {DW{1'b0}};
                if (h_last_s) begin
                    h_cnt_r <= {HW{1'b0}};
                    if (v_last_s) begin
                        v_cnt_r <= {VW{1'b0}};
                    end else begin
                        v_cnt_r <= v_cnt_r + V_ONE;
                    end
                end else begin
                    h_cnt_r <= h_cnt_r + H_ONE;
                end
            end else begin
                div_r <= div_r + DIV_ONE;
            end
        end
    end

    // Tile sub-counters: col/row follow the raster without a divider and are
    // re-zeroed on the tick just before the board edge is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r  <= {TW{1'b0}};
            ty_r  <= {TW{1'b0}};
            col_r <= 2'd0;
            row_r <= 2'd0;
        end else if (tick_s) begin
            if (h_cnt_r == BX0_PRE) begin
                tx_r  <= {TW{1'b0}};
                col_r <= 2'd0;
            end else if (h_in_s) begin
                if (tx_r == T_LAST) begin
                    tx_r  <= {TW{1'b0}};
                    col_r <= col_r + 2'd1;
                end else begin
                    tx_r <= tx_r + T_ONE;
                end
            end else begin
                tx_r <= tx_r;
            end
            if (h_last_s && (v_cnt_r == BY0_PRE)) begin
                ty_r  <= {TW{1'b0}};
                row_r <= 2'd0;
            end else if (h_last_s && v_in_s) begin
                if (ty_r == T_LAST) begin
                    ty_r  <= {TW{1'b0}};
                    row_r <= row_r + 2'd1;
                end else begin
                    ty_r <= ty_r + T_ONE;
                end
            end else begin
                ty_r <= ty_r;
            end
        end else begin
            tx_r <= tx_r;
        end
    end

    // Stages 1 and 2 of the pixel pipeline plus the frame-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            block_id_r    <= 4'd0;
            in_board_1_r  <= 1'b0;
            active_1_r    <= 1'b0;
            hs_1_r        <= 1'b1;
            vs_1_r        <= 1'b1;
            rgb_r         <= 12'h000;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            frame_start_r <= 1'b0;
`ifdef TILE_GRID_EN
            tx_1_r        <= {TW{1'b0}};
            ty_1_r        <= {TW{1'b0}};
`endif
        end else if (tick_s) begin
            // BlockID keeps the last board tile while the beam is off-board
            if (in_board_s) begin
                block_id_r <= {row_r, col_r};
            end else begin
                block_id_r <= block_id_r;
            end
            in_board_1_r  <= in_board_s;
            active_1_r    <= active_s;
            hs_1_r        <= hs_n_s;
            vs_1_r        <= vs_n_s;
`ifdef TILE_GRID_EN
            tx_1_r        <= tx_r;
            ty_1_r        <= ty_r;
`endif
            rgb_r         <= colour_s;
            hs_r          <= hs_1_r;
            vs_r          <= vs_1_r;
            frame_start_r <= (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    assign BlockID     = block_id_r;
    assign vga_r       = rgb_r[11:8];
    assign vga_g       = rgb_r[7:4];
    assign vga_b       = rgb_r[3:0];
    assign vga_hs      = hs_r;
    assign vga_vs      = vs_r;
    assign frame_start = frame_start_r;
endmodule

// File: tb/tb_tile_board_scanner.sv
// Bench for tile_board_scanner. Two instances share clock and reset:
//   index 0 : full 640x480 geometry, covering line timing and off-board colours
//   index 1 : shrunken geometry, so that whole frames, every board tile and
//             the frame wrap fit in a short run
// A bus model answers BlockID with a table lookup only on the cycle before a
// tick and with random values otherwise. A raster model pushes the expected
// {rgb, hs, vs} per tick into a scoreboard queue, and entries are compared one
// tick later, when the pipeline presents them.
`timescale 1ns/1ps
module tb_tile_board_scanner;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] d_bid, d_bt, d_r, d_g, d_b;
    logic       d_hs, d_vs, d_fs;
    logic [3:0] s_bid, s_bt, s_r, s_g, s_b;
    logic       s_hs, s_vs, s_fs;

    tile_board_scanner dut_full (
        .clk(clk), .rst(rst), .BlockID(d_bid), .BlockType(d_bt),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs(d_hs), .vga_vs(d_vs), .frame_start(d_fs)
    );

    tile_board_scanner #(
        .PIX_DIV(4), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .BOARD_X0(8), .BOARD_Y0(5), .TILE_PX(6)
    ) dut_small (
        .clk(clk), .rst(rst), .BlockID(s_bid), .BlockType(s_bt),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .frame_start(s_fs)
    );

    int g_hact[2]  = '{640, 40};
    int g_hfp[2]   = '{16, 4};
    int g_hsync[2] = '{96, 8};
    int g_htot[2]  = '{800, 56};
    int g_vact[2]  = '{480, 30};
    int g_vfp[2]   = '{10, 2};
    int g_vsync[2] = '{2, 2};
    int g_vtot[2]  = '{525, 37};
    int g_bx0[2]   = '{160, 8};
    int g_by0[2]   = '{80, 5};
    int g_tp[2]    = '{80, 6};

    logic [11:0] pal[16] = '{12'hCCB, 12'hEED, 12'hEEC, 12'hFB7, 12'hF96, 12'hF75,
                             12'hF53, 12'hEC7, 12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2,
                             12'h333, 12'h333, 12'h333, 12'h333};
    logic [3:0] bt_tab[16];

    typedef struct packed {
        logic [13:0] e0;
        logic [13:0] e1;
    } sb_ent_t;
    sb_ent_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int mdiv, tick_n, hs_low;
    int mh[2], mv[2];
    logic [3:0] ebid[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {in_board, tile index} of raster position (h, v) for instance d
    function automatic logic [4:0] tile_of(input int d, input int h, input int v);
        int col, row;
        if (h >= g_bx0[d] && h < g_bx0[d] + 4 * g_tp[d] &&
            v >= g_by0[d] && v < g_by0[d] + 4 * g_tp[d]) begin
            col = (h - g_bx0[d]) / g_tp[d];
            row = (v - g_by0[d]) / g_tp[d];
            return {1'b1, 4'(row * 4 + col)};
        end
        return 5'd0;
    endfunction

    function automatic logic [13:0] exp_pixel(input int d, input int h, input int v);
        logic [4:0]  t;
        logic [11:0] rgb;
        logic        hs, vs;
        t = tile_of(d, h, v);
        if (t[4]) begin
            rgb = pal[bt_tab[t[3:0]]];
`ifdef TILE_GRID_EN
            if (((h - g_bx0[d]) % g_tp[d]) < 2 || ((v - g_by0[d]) % g_tp[d]) < 2)
                rgb = 12'h776;
`endif
        end else if (h < g_hact[d] && v < g_vact[d]) begin
            rgb = 12'h444;
        end else begin
            rgb = 12'h000;
        end
        hs = !(h >= g_hact[d] + g_hfp[d] && h < g_hact[d] + g_hfp[d] + g_hsync[d]);
        vs = !(v >= g_vact[d] + g_vfp[d] && v < g_vact[d] + g_vfp[d] + g_vsync[d]);
        return {rgb, hs, vs};
    endfunction

    task automatic step();
        logic    r, tk;
        logic [4:0] t;
        sb_ent_t ent;
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            mdiv = 0; tick_n = 0; hs_low = 0;
            mh = '{0, 0}; mv = '{0, 0};
            ebid = '{4'd0, 4'd0};
            sb.delete();
            check_eq("rst_bid_full", 32'(d_bid), 32'd0);
            check_eq("rst_rgb_full", 32'({d_r, d_g, d_b}), 32'h000);
            check_eq("rst_sync_full", 32'({d_hs, d_vs}), 32'd3);
            check_eq("rst_fs_full", 32'(d_fs), 32'd0);
            check_eq("rst_bid_small", 32'(s_bid), 32'd0);
            check_eq("rst_rgb_small", 32'({s_r, s_g, s_b}), 32'h000);
            check_eq("rst_sync_small", 32'({s_hs, s_vs}), 32'd3);
            check_eq("rst_fs_small", 32'(s_fs), 32'd0);
        end else begin
            tk = (mdiv == 3);
            mdiv = (mdiv + 1) % 4;
            check_eq("fs_full", 32'(d_fs), 32'(tk && mh[0] == 0 && mv[0] == 0));
            check_eq("fs_small", 32'(s_fs), 32'(tk && mh[1] == 0 && mv[1] == 0));
            if (tk) begin
                tick_n++;
                ent.e0 = exp_pixel(0, mh[0], mv[0]);
                ent.e1 = exp_pixel(1, mh[1], mv[1]);
                sb.push_back(ent);
                for (int d = 0; d < 2; d++) begin
                    t = tile_of(d, mh[d], mv[d]);
                    if (t[4]) ebid[d] = t[3:0];
                    mh[d]++;
                    if (mh[d] == g_htot[d]) begin
                        mh[d] = 0;
                        mv[d]++;
                        if (mv[d] == g_vtot[d]) mv[d] = 0;
                    end
                end
                check_eq("bid_full", 32'(d_bid), 32'(ebid[0]));
                check_eq("bid_small", 32'(s_bid), 32'(ebid[1]));
                if (sb.size() == 2) begin
                    ent = sb.pop_front();
                    check_eq("rgb_full", 32'({d_r, d_g, d_b}), 32'(ent.e0[13:2]));
                    check_eq("hs_full", 32'(d_hs), 32'(ent.e0[1]));
                    check_eq("vs_full", 32'(d_vs), 32'(ent.e0[0]));
                    check_eq("rgb_small", 32'({s_r, s_g, s_b}), 32'(ent.e1[13:2]));
                    check_eq("hs_small", 32'(s_hs), 32'(ent.e1[1]));
                    check_eq("vs_small", 32'(s_vs), 32'(ent.e1[0]));
                end
                if (!d_hs) hs_low++;
                if (tick_n == 800) check_eq("hs_width_line0", 32'(hs_low), 32'd96);
            end
        end
        // Bus model: the proper table entry only at the edge that samples it
        if (mdiv == 3) begin
            d_bt = bt_tab[d_bid];
            s_bt = bt_tab[s_bid];
        end else begin
            d_bt = 4'($urandom);
            s_bt = 4'($urandom);
        end
    endtask

    initial begin
        // Odd-stride permutation: every palette entry is reached, entry 6 -> 5
        for (int i = 0; i < 16; i++) bt_tab[i] = 4'((7 * i + 11) % 16);
        mdiv = 0;
        rst  = 1'b1;
        d_bt = 4'd0;
        s_bt = 4'd0;
        repeat (3) step();
        rst = 1'b0;
        repeat (20000) step();
        // Mid-frame reset: the small instance is inside its board here
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (13000) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
